// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY register-bus arbiter: FSM states and chip-select codes.
package pokey_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WHOLD = 2'd2,
        RCAP  = 2'd3
    } state_t;

    localparam logic [1:0] CS_SEL  = 2'b10;
    localparam logic [1:0] CS_IDLE = 2'b01;

endpackage

// File: rtl/pokey_bus_arbiter.sv
// Two-port arbiter in front of IO_core: grants one register access at a time and
// sequences it against the enp slot strobe. All outputs are registered.
module pokey_bus_arbiter
    import pokey_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int WR_HOLD   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enp,
    // Handshake: reqN is the valid and must be held until ackN; ackN is a one-clk
    // completion pulse and rdataN is only meaningful while ackN is high.
    input  logic       req0,
    input  logic       we0,
    input  logic [3:0] addr0,
    input  logic [7:0] wdata0,
    output logic       ack0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack1,
    output logic [7:0] rdata1,
    output logic       RW,
    output logic [1:0] CS,
    output logic [3:0] A,
    output logic [7:0] Dataw,
    input  logic [7:0] Datar,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] HOLD_INIT = 2'(WR_HOLD);

    state_t     state, state_n;
    logic       port_q, port_n;
    logic       we_q, we_n;
    logic       ptr_q, ptr_n;
    logic [1:0] cnt_q, cnt_n;

    logic       rw_n, ack0_n, ack1_n, busy_n;
    logic [1:0] cs_n;
    logic [3:0] a_n;
    logic [7:0] dataw_n, rdata0_n, rdata1_n;

    logic       gnt, sel_we;
    logic [3:0] sel_addr;
    logic [7:0] sel_wdata;

    // Winner when both request: the pointer in round-robin mode, port 0 in fixed mode.
    always_comb begin
        gnt = ~req0;
        if (req0 && req1) begin
            gnt = (PRIO_MODE == 1) ? 1'b0 : ptr_q;
        end
        sel_we    = gnt ? we1    : we0;
        sel_addr  = gnt ? addr1  : addr0;
        sel_wdata = gnt ? wdata1 : wdata0;
    end

    always_comb begin
        state_n  = state;
        port_n   = port_q;
        we_n     = we_q;
        ptr_n    = ptr_q;
        cnt_n    = cnt_q;
        rw_n     = RW;
        cs_n     = CS;
        a_n      = A;
        dataw_n  = Dataw;
        rdata0_n = rdata0;
        rdata1_n = rdata1;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    port_n  = gnt;
                    we_n    = sel_we;
                    ptr_n   = ~gnt;
                    rw_n    = ~sel_we;
                    cs_n    = CS_SEL;
                    a_n     = sel_addr;
                    if (sel_we) begin
                        dataw_n = sel_wdata;
                    end
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (enp) begin
                    cs_n = CS_IDLE;
                    rw_n = 1'b1;
                    if (we_q) begin
                        cnt_n   = HOLD_INIT;
                        state_n = WHOLD;
                    end else begin
                        state_n = RCAP;
                    end
                end
            end
            WHOLD: begin
                if (enp) begin
                    if (cnt_q == 2'd1) begin
                        ack0_n  = ~port_q;
                        ack1_n  = port_q;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q - 2'd1;
                    end
                end
            end
            RCAP: begin
                if (port_q) begin
                    rdata1_n = Datar;
                end else begin
                    rdata0_n = Datar;
                end
                ack0_n  = ~port_q;
                ack1_n  = port_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            port_q <= 1'b0;
            we_q   <= 1'b0;
            ptr_q  <= 1'b0;
            cnt_q  <= 2'd0;
            RW     <= 1'b1;
            CS     <= CS_IDLE;
            A      <= 4'd0;
            Dataw  <= 8'd0;
            rdata0 <= 8'd0;
            rdata1 <= 8'd0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            port_q <= port_n;
            we_q   <= we_n;
            ptr_q  <= ptr_n;
            cnt_q  <= cnt_n;
            RW     <= rw_n;
            CS     <= cs_n;
            A      <= a_n;
            Dataw  <= dataw_n;
            rdata0 <= rdata0_n;
            rdata1 <= rdata1_n;
            ack0   <= ack0_n;
            ack1   <= ack1_n;
            busy   <= busy_n;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// Bench for pokey_bus_arbiter: a round-robin/WR_HOLD=1 instance and a fixed-priority/
// WR_HOLD=2 instance, each tracked by a slot-counting transaction model.
module tb_pokey_bus_arbiter;
    import pokey_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n [2];
    logic       enp;
    logic       req   [2][2];
    logic       we    [2][2];
    logic [3:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic       ack   [2][2];
    logic [7:0] rdata [2][2];
    logic       rw    [2];
    logic [1:0] cs    [2];
    logic [3:0] a     [2];
    logic [7:0] dataw [2];
    logic [7:0] datar [2];
    logic       busy  [2];
    logic [1:0] dbg   [2];
    logic [7:0] mem   [16];

    // IO_core stand-in: read mux is a fixed register image
    assign datar[0] = mem[a[0]];
    assign datar[1] = mem[a[1]];

    pokey_bus_arbiter #(.PRIO_MODE(0), .WR_HOLD(1)) u_rr (
        .clk(clk), .reset_n(rst_n[0]), .enp(enp),
        .req0(req[0][0]), .we0(we[0][0]), .addr0(addr[0][0]), .wdata0(wdata[0][0]),
        .ack0(ack[0][0]), .rdata0(rdata[0][0]),
        .req1(req[0][1]), .we1(we[0][1]), .addr1(addr[0][1]), .wdata1(wdata[0][1]),
        .ack1(ack[0][1]), .rdata1(rdata[0][1]),
        .RW(rw[0]), .CS(cs[0]), .A(a[0]), .Dataw(dataw[0]), .Datar(datar[0]),
        .busy(busy[0]), .dbg_state(dbg[0])
    );

    pokey_bus_arbiter #(.PRIO_MODE(1), .WR_HOLD(2)) u_fp (
        .clk(clk), .reset_n(rst_n[1]), .enp(enp),
        .req0(req[1][0]), .we0(we[1][0]), .addr0(addr[1][0]), .wdata0(wdata[1][0]),
        .ack0(ack[1][0]), .rdata0(rdata[1][0]),
        .req1(req[1][1]), .we1(we[1][1]), .addr1(addr[1][1]), .wdata1(wdata[1][1]),
        .ack1(ack[1][1]), .rdata1(rdata[1][1]),
        .RW(rw[1]), .CS(cs[1]), .A(a[1]), .Dataw(dataw[1]), .Datar(datar[1]),
        .busy(busy[1]), .dbg_state(dbg[1])
    );

    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   enp_mode = 0;
    logic enp_manual = 1'b0;

    function automatic int wh_of(input int i);
        return i + 1;
    endfunction

    function automatic int prio_of(input int i);
        return i;
    endfunction

    // ---------------- transaction model ----------------
    logic       m_act [2], m_port [2], m_we [2], m_sel [2], m_cap [2], m_ptr [2];
    logic [3:0] m_addr [2];
    int         m_slots [2];
    logic       e_rw [2], e_busy [2];
    logic [1:0] e_cs [2];
    logic [3:0] e_a [2];
    logic [7:0] e_dataw [2];
    logic       e_ack [2][2];
    logic [7:0] e_rdata [2][2];

    task automatic model_reset(input int i);
        m_act[i] = 0; m_port[i] = 0; m_we[i] = 0; m_sel[i] = 0; m_cap[i] = 0;
        m_ptr[i] = 0; m_addr[i] = 0; m_slots[i] = 0;
        e_rw[i] = 1; e_cs[i] = CS_IDLE; e_a[i] = 0; e_dataw[i] = 0; e_busy[i] = 0;
        e_ack[i][0] = 0; e_ack[i][1] = 0; e_rdata[i][0] = 0; e_rdata[i][1] = 0;
    endtask

    // An access consumes one enp slot (writes: plus WR_HOLD), reads then need one capture clk.
    task automatic model_step(input int i);
        logic w;
        e_ack[i][0] = 0;
        e_ack[i][1] = 0;
        if (!m_act[i]) begin
            if (req[i][0] || req[i][1]) begin
                w = req[i][0] ? 1'b0 : 1'b1;
                if (req[i][0] && req[i][1] && prio_of(i) == 0) w = m_ptr[i];
                m_ptr[i]   = !w;
                m_act[i]   = 1;
                m_port[i]  = w;
                m_we[i]    = we[i][w];
                m_addr[i]  = addr[i][w];
                m_slots[i] = m_we[i] ? 1 + wh_of(i) : 1;
                m_sel[i]   = 1;
                m_cap[i]   = 0;
                e_rw[i]    = !m_we[i];
                e_cs[i]    = CS_SEL;
                e_a[i]     = m_addr[i];
                if (m_we[i]) e_dataw[i] = wdata[i][w];
            end
        end else if (m_cap[i]) begin
            e_rdata[i][m_port[i]] = mem[m_addr[i]];
            e_ack[i][m_port[i]]   = 1;
            m_act[i] = 0;
            m_cap[i] = 0;
        end else if (enp) begin
            m_slots[i]--;
            if (m_sel[i]) begin
                m_sel[i] = 0;
                e_cs[i]  = CS_IDLE;
                e_rw[i]  = 1;
            end
            if (m_slots[i] == 0) begin
                if (m_we[i]) begin
                    e_ack[i][m_port[i]] = 1;
                    m_act[i] = 0;
                end else begin
                    m_cap[i] = 1;
                end
            end
        end
        e_busy[i] = m_act[i];
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) model_reset(i);
            else model_step(i);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int i, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s inst%0d: got %h want %h (cycle %0d)", name, i, got, want, cyc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check("RW",     i, {7'd0, rw[i]},      {7'd0, e_rw[i]});
            check("CS",     i, {6'd0, cs[i]},      {6'd0, e_cs[i]});
            check("A",      i, {4'd0, a[i]},       {4'd0, e_a[i]});
            check("Dataw",  i, dataw[i],           e_dataw[i]);
            check("ack0",   i, {7'd0, ack[i][0]},  {7'd0, e_ack[i][0]});
            check("ack1",   i, {7'd0, ack[i][1]},  {7'd0, e_ack[i][1]});
            check("rdata0", i, rdata[i][0],        e_rdata[i][0]);
            check("rdata1", i, rdata[i][1],        e_rdata[i][1]);
            check("busy",   i, {7'd0, busy[i]},    {7'd0, e_busy[i]});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
        compare_all();
        #1;
        cyc++;
        case (enp_mode)
            0:       enp = 1'b0;
            1:       enp = (cyc % 4 == 0);
            2:       enp = ($urandom_range(0, 2) == 0);
            3:       enp = 1'b1;
            default: enp = enp_manual;
        endcase
    endtask

    task automatic raise(input int i, input int p, input logic w, input logic [3:0] ad, input logic [7:0] wd);
        req[i][p]   = 1'b1;
        we[i][p]    = w;
        addr[i][p]  = ad;
        wdata[i][p] = wd;
    endtask

    task automatic wait_ack(input int i, input int p, output int lat);
        logic seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            tick();
            lat++;
            seen = ack[i][p];
        end
        tests++;
        if (!seen) begin
            failures++;
            $display("FAIL ack_timeout inst%0d port%0d: got no ack, want ack within 200 clk", i, p);
        end
        req[i][p] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        int   lat, n, exp_g, got_g;
        logic any_req;
        int   grants[$];

        enp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 0; we[i][p] = 0; addr[i][p] = 0; wdata[i][p] = 0;
            end
        end
        for (int k = 0; k < 16; k++) mem[k] = 8'($urandom_range(0, 255));
        mem[10] = 8'h5C;
        mem[11] = 8'hFF;
        mem[12] = 8'hFF;

        // reset held while requests toggle
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                check("rst_RW",   i, {7'd0, rw[i]},     8'd1);
                check("rst_CS",   i, {6'd0, cs[i]},     8'd1);
                check("rst_A",    i, {4'd0, a[i]},      8'd0);
                check("rst_ack",  i, {6'd0, ack[i][1], ack[i][0]}, 8'd0);
                for (int p = 0; p < 2; p++) req[i][p] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            req[i][0] = 0; req[i][1] = 0; rst_n[i] = 1'b1;
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rel_busy", i, {7'd0, busy[i]}, 8'd0);
            check("rel_idle", i, {6'd0, dbg[i]},  8'd0);
        end

        // read of register A with enp every 4 clk
        enp_mode = 1;
        raise(0, 0, 1'b0, 4'hA, 8'h00);
        wait_ack(0, 0, lat);
        check("rd_5C", 0, rdata[0][0], 8'h5C);
        tick();
        check("ack_one_clk", 0, {7'd0, ack[0][0]}, 8'd0);

        // port 1 write, Dataw persists afterwards
        raise(0, 1, 1'b1, 4'h1, 8'hA7);
        wait_ack(0, 1, lat);
        check("wr_dataw", 0, dataw[0], 8'hA7);
        repeat (3) tick();
        check("dataw_hold", 0, dataw[0], 8'hA7);

        // unmapped address reads whatever IO_core returns
        raise(0, 0, 1'b0, 4'hC, 8'h00);
        wait_ack(0, 0, lat);
        check("rd_unmapped", 0, rdata[0][0], 8'hFF);

        // enp always high: minimum latencies
        enp_mode = 3;
        tick();
        raise(0, 0, 1'b0, 4'h3, 8'h00);
        wait_ack(0, 0, lat);
        check("rd_lat", 0, 8'(lat), 8'd3);
        raise(0, 1, 1'b1, 4'h2, 8'h11);
        wait_ack(0, 1, lat);
        check("wr_lat_wh1", 0, 8'(lat), 8'd3);
        raise(1, 0, 1'b1, 4'h2, 8'h22);
        wait_ack(1, 0, lat);
        check("wr_lat_wh2", 1, 8'(lat), 8'd4);

        // enp held low: access parks in ISSUE
        enp_mode = 0;
        tick();
        raise(0, 0, 1'b0, 4'h5, 8'h00);
        repeat (10) tick();
        check("stall_busy",  0, {7'd0, busy[0]}, 8'd1);
        check("stall_cs",    0, {6'd0, cs[0]},   8'd2);
        check("stall_issue", 0, {6'd0, dbg[0]},  8'd1);
        enp_mode = 1;
        wait_ack(0, 0, lat);
        check("stall_rd", 0, rdata[0][0], mem[5]);

        // request dropped and fields changed after grant
        raise(0, 1, 1'b0, 4'h3, 8'h00);
        tick();
        req[0][1] = 0; addr[0][1] = 4'h7; we[0][1] = 1'b1;
        wait_ack(0, 1, lat);
        check("early_drop_rd", 0, rdata[0][1], mem[3]);

        // reset during WHOLD
        enp_mode = 4;
        enp_manual = 1'b0;
        tick();
        raise(0, 0, 1'b1, 4'h2, 8'h3C);
        tick();
        tick();
        enp_manual = 1'b1;
        tick();
        enp_manual = 1'b0;
        tick();
        check("in_whold", 0, {6'd0, dbg[0]}, 8'd2);
        rst_n[0] = 1'b0;
        req[0][0] = 1'b0;
        #1;
        check("rst_mid_cs",    0, {6'd0, cs[0]},     8'd1);
        check("rst_mid_dataw", 0, dataw[0],          8'd0);
        check("rst_mid_busy",  0, {7'd0, busy[0]},   8'd0);
        check("rst_mid_ack",   0, {7'd0, ack[0][0]}, 8'd0);
        tick();
        tick();
        rst_n[0] = 1'b1;
        tick();
        enp_mode = 1;
        raise(0, 0, 1'b0, 4'hA, 8'h00);
        wait_ack(0, 0, lat);
        check("fresh_rd", 0, rdata[0][0], 8'h5C);

        // both ports requesting continuously
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            tick();
            rst_n[k] = 1'b1;
            tick();
            enp_mode = 3;
            raise(k, 0, 1'b0, 4'h4, 8'h00);
            raise(k, 1, 1'b0, 4'h5, 8'h00);
            grants.delete();
            n = 0;
            while (grants.size() < 6 && n < 200) begin
                tick();
                n++;
                if (ack[k][0]) grants.push_back(0);
                if (ack[k][1]) grants.push_back(1);
            end
            req[k][0] = 0;
            req[k][1] = 0;
            for (int j = 0; j < 6; j++) begin
                exp_g = (prio_of(k) == 1) ? 0 : j % 2;
                got_g = (j < grants.size()) ? grants[j] : 9;
                check("grant_seq", k, 8'(got_g), 8'(exp_g));
            end
            repeat (8) tick();
        end

        // randomized traffic on both instances
        enp_mode = 2;
        repeat (2500) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (req[i][p] && ack[i][p]) begin
                        req[i][p] = 1'b0;
                    end else if (req[i][p] && $urandom_range(0, 7) == 0) begin
                        we[i][p]    = 1'($urandom_range(0, 1));
                        addr[i][p]  = 4'($urandom_range(0, 15));
                        wdata[i][p] = 8'($urandom_range(0, 255));
                    end else if (!req[i][p] && $urandom_range(0, 3) == 0) begin
                        raise(i, p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              8'($urandom_range(0, 255)));
                    end
                end
            end
        end
        n = 0;
        any_req = 1'b1;
        while (any_req && n < 400) begin
            tick();
            n++;
            any_req = 1'b0;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (req[i][p] && ack[i][p]) req[i][p] = 1'b0;
                    any_req = any_req | req[i][p];
                end
            end
        end
        check("drain", 0, {7'd0, any_req}, 8'd0);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
